led_pattern_gen: RTL and testbench

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

---
 rtl/led_pattern_gen.sv | 166 ++++++++++++++++
 tb/tb_led_pattern_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// led_pattern_gen
//   Generates a 16-bit LED pattern for the serial LED driver. At a programmable
//   step rate, the pattern holds, rotates left, rotates right, or bounces a
//   pattern between the two ends (ping-pong).
//
//   Ports
//     clk        system clock; all state changes on the rising edge
//     rst        asynchronous, active-high reset
//     mode[1:0]  00 HOLD, 01 ROTL, 10 ROTR, 11 PINGPONG
//     speed[1:0] step period = PRE_DIV << speed clock cycles
//     pause      while high, the prescaler and the pattern are frozen
//     sw_load    level input; its rising edge loads sw into the pattern
//     sw[15:0]   load value; bit 15 is the leftmost LED
//     HEXS[15:0] current pattern (registered)
//     step_tick  one-cycle pulse in the cycle in which a step result is visible
//     dir        ping-pong direction, 0 = toward bit 15, 1 = toward bit 0
//
//   Control interface: there is no valid/ready handshake. Every input is a
//   level that is sampled on each rising clock edge. sw_load is edge-detected
//   against its previous sampled value. Priority, highest first: reset,
//   sw_load rising edge, mode change, step.

module led_pattern_gen #(
   parameter int PRE_DIV = 1048576
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  mode,
   input  logic [1:0]  speed,
   input  logic        pause,
   input  logic        sw_load,
   input  logic [15:0] sw,
   output logic [15:0] HEXS,
   output logic        step_tick,
   output logic        dir
);

   // The counter must reach (PRE_DIV << 3) - 1, which is the slowest limit.
   localparam int CNT_W = $clog2(PRE_DIV << 3);

   localparam logic [CNT_W-1:0] LIM_S0 = CNT_W'((PRE_DIV << 0) - 1);
   localparam logic [CNT_W-1:0] LIM_S1 = CNT_W'((PRE_DIV << 1) - 1);
   localparam logic [CNT_W-1:0] LIM_S2 = CNT_W'((PRE_DIV << 2) - 1);
   localparam logic [CNT_W-1:0] LIM_S3 = CNT_W'((PRE_DIV << 3) - 1);

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_ROTL = 2'b01;
   localparam logic [1:0] MODE_ROTR = 2'b10;
   localparam logic [1:0] MODE_PING = 2'b11;

   // Ping-pong direction state. The dir output exposes it directly.
   typedef enum logic {
      PP_LEFT  = 1'b0,
      PP_RIGHT = 1'b1
   } pp_state_t;

   logic [CNT_W-1:0] cnt_q,  cnt_d;
   logic [15:0]      hexs_q, hexs_d;
   pp_state_t        state_q, state_d;
   logic             tick_q, tick_d;
   logic [1:0]       mode_q;
   logic             sw_load_q;

   logic [CNT_W-1:0] limit;
   logic             load_edge;
   logic             mode_chg;

   assign load_edge = sw_load & ~sw_load_q;
   assign mode_chg  = (mode != mode_q);

   always_comb begin
      limit = LIM_S0;
      case (speed)
         2'd0:    limit = LIM_S0;
         2'd1:    limit = LIM_S1;
         2'd2:    limit = LIM_S2;
         default: limit = LIM_S3;
      endcase
   end

   always_comb begin
      cnt_d   = cnt_q;
      hexs_d  = hexs_q;
      state_d = state_q;
      tick_d  = 1'b0;

      if (load_edge) begin
         // The load takes priority, but it still honours the direction
         // reset that a simultaneous mode change implies.
         hexs_d = sw;
         cnt_d  = '0;
         if (mode_chg) begin
            state_d = PP_LEFT;
         end
      end else if (mode_chg) begin
         cnt_d   = '0;
         state_d = PP_LEFT;
         if (mode == MODE_PING) begin
            hexs_d = 16'h0001;
         end
      end else if (!pause) begin
         if (cnt_q > limit) begin
            // The speed was lowered below the current count: restart the
            // period without stepping.
            cnt_d = '0;
         end else if (cnt_q == limit) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            case (mode)
               MODE_HOLD: hexs_d = hexs_q;
               MODE_ROTL: hexs_d = {hexs_q[14:0], hexs_q[15]};
               MODE_ROTR: hexs_d = {hexs_q[0], hexs_q[15:1]};
               MODE_PING: begin
                  if (hexs_q == 16'h0000) begin
                     // An empty pattern would never bounce, so reseed it.
                     hexs_d  = 16'h0001;
                     state_d = PP_LEFT;
                  end else if (state_q == PP_LEFT) begin
                     if (hexs_q[15]) begin
                        state_d = PP_RIGHT;
                        hexs_d  = {1'b0, hexs_q[15:1]};
                     end else begin
                        hexs_d  = {hexs_q[14:0], 1'b0};
                     end
                  end else begin
                     if (hexs_q[0]) begin
                        state_d = PP_LEFT;
                        hexs_d  = {hexs_q[14:0], 1'b0};
                     end else begin
                        hexs_d  = {1'b0, hexs_q[15:1]};
                     end
                  end
               end
               default: hexs_d = hexs_q;
            endcase
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // sw_load_q resets to 1 so that sw_load held high through reset release
   // is not seen as a rising edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= '0;
         hexs_q    <= 16'h0001;
         state_q   <= PP_LEFT;
         tick_q    <= 1'b0;
         mode_q    <= MODE_HOLD;
         sw_load_q <= 1'b1;
      end else begin
         cnt_q     <= cnt_d;
         hexs_q    <= hexs_d;
         state_q   <= state_d;
         tick_q    <= tick_d;
         mode_q    <= mode;
         sw_load_q <= sw_load;
      end
   end

   assign HEXS      = hexs_q;
   assign step_tick = tick_q;
   assign dir       = (state_q == PP_RIGHT);

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen
//   Directed testbench for led_pattern_gen with PRE_DIV = 4. Inputs change
//   1 time unit after a rising edge, and outputs are read at the same point.

module tb_led_pattern_gen;

   localparam int PRE_DIV = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  mode;
   logic [1:0]  speed;
   logic        pause;
   logic        sw_load;
   logic [15:0] sw;
   logic [15:0] HEXS;
   logic        step_tick;
   logic        dir;

   int n_chk  = 0;
   int n_pass = 0;

   led_pattern_gen #(.PRE_DIV(PRE_DIV)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .speed     (speed),
      .pause     (pause),
      .sw_load   (sw_load),
      .sw        (sw),
      .HEXS      (HEXS),
      .step_tick (step_tick),
      .dir       (dir)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advances edges until step_tick is seen or the budget runs out. It returns
   // the number of edges that were taken.
   task automatic wait_step(input int budget, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (step_tick !== 1'b1 && n < budget);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int        n;
      logic [15:0] exp;
      logic      saw;

      rst = 1'b1; mode = 2'b01; speed = 2'd0; pause = 1'b0;
      sw_load = 1'b0; sw = 16'h0000;
      tick(); tick();
      check("rst_hexs", 32'(HEXS), 32'h0001);
      check("rst_dir",  32'(dir), 0);
      check("rst_tick", 32'(step_tick), 0);

      // ROTL: the mode change out of reset (00 -> 01) costs one edge.
      rst = 1'b0;
      wait_step(20, n);
      check("rotl_first_lat", n, 5);
      check("rotl_s1", 32'(HEXS), 32'h0002);
      tick();
      check("tick_one_cycle", 32'(step_tick), 0);
      wait_step(20, n);
      check("rotl_gap2", n, 3);
      check("rotl_s2", 32'(HEXS), 32'h0004);
      exp = 16'h0004;
      for (int i = 3; i <= 16; i++) begin
         exp = {exp[14:0], exp[15]};
         wait_step(20, n);
         check("rotl_gap", n, 4);
         check("rotl_val", 32'(HEXS), 32'(exp));
      end
      check("rotl_wrap", 32'(HEXS), 32'h0001);

      // ROTR at speed 2: the load edge wins over the mode change.
      mode = 2'b10; speed = 2'd2; sw = 16'h8001; sw_load = 1'b1;
      tick();
      check("rotr_load", 32'(HEXS), 32'h8001);
      check("rotr_load_tick", 32'(step_tick), 0);
      sw_load = 1'b0;
      wait_step(40, n);
      check("rotr_gap1", n, 16);
      check("rotr_s1", 32'(HEXS), 32'hC000);
      wait_step(40, n);
      check("rotr_gap2", n, 16);
      check("rotr_s2", 32'(HEXS), 32'h6000);

      // Pause mid-count: 5 counts done, 11 edges remain after release.
      repeat (5) tick();
      pause = 1'b1;
      saw = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (step_tick === 1'b1) saw = 1'b1;
      end
      check("pause_no_tick", 32'(saw), 0);
      check("pause_hexs", 32'(HEXS), 32'h6000);
      pause = 1'b0;
      wait_step(40, n);
      check("pause_resume_gap", n, 11);
      check("pause_resume_val", 32'(HEXS), 32'h3000);

      // A load still works while paused, and holding sw_load high loads once.
      pause = 1'b1; sw = 16'h00F0; sw_load = 1'b1;
      tick();
      check("pause_load", 32'(HEXS), 32'h00F0);
      check("pause_load_tick", 32'(step_tick), 0);
      sw = 16'h1234;
      repeat (3) tick();
      check("load_once", 32'(HEXS), 32'h00F0);

      // A speed drop below the current count restarts the period.
      pause = 1'b0; sw_load = 1'b0;
      repeat (10) tick();
      check("pre_speed_tick", 32'(step_tick), 0);
      check("pre_speed_hexs", 32'(HEXS), 32'h00F0);
      speed = 2'd0;
      wait_step(20, n);
      check("speed_drop_gap", n, 5);
      check("speed_drop_val", 32'(HEXS), 32'h0078);

      // PINGPONG entered from ROTL.
      mode = 2'b01;
      tick();
      mode = 2'b11;
      tick();
      check("pp_entry", 32'(HEXS), 32'h0001);
      check("pp_entry_dir", 32'(dir), 0);
      check("pp_entry_tick", 32'(step_tick), 0);
      for (int i = 1; i <= 31; i++) begin
         wait_step(20, n);
         check("pp_gap", n, 4);
         if (i == 15) begin
            check("pp_s15", 32'(HEXS), 32'h8000);
            check("pp_s15_dir", 32'(dir), 0);
         end
         if (i == 16) begin
            check("pp_s16", 32'(HEXS), 32'h4000);
            check("pp_s16_dir", 32'(dir), 1);
         end
         if (i == 30) begin
            check("pp_s30", 32'(HEXS), 32'h0001);
            check("pp_s30_dir", 32'(dir), 1);
         end
         if (i == 31) begin
            check("pp_s31", 32'(HEXS), 32'h0002);
            check("pp_s31_dir", 32'(dir), 0);
         end
      end

      // PINGPONG with an empty pattern reseeds with 0001.
      sw = 16'h0000; sw_load = 1'b1;
      tick();
      check("pp_zero_load", 32'(HEXS), 32'h0000);
      sw_load = 1'b0;
      wait_step(20, n);
      check("pp_zero_gap", n, 4);
      check("pp_zero_step", 32'(HEXS), 32'h0001);
      check("pp_zero_dir", 32'(dir), 0);

      // HOLD still pulses step_tick but keeps the pattern.
      mode = 2'b00;
      tick();
      check("hold_entry", 32'(HEXS), 32'h0001);
      wait_step(20, n);
      check("hold_gap", n, 4);
      check("hold_val", 32'(HEXS), 32'h0001);

      // A load edge plus a change into PINGPONG in the same cycle loads sw.
      mode = 2'b01;
      tick();
      sw = 16'h0300; sw_load = 1'b1; mode = 2'b11;
      tick();
      check("combo_hexs", 32'(HEXS), 32'h0300);
      check("combo_dir", 32'(dir), 0);
      check("combo_tick", 32'(step_tick), 0);
      sw_load = 1'b0;
      wait_step(20, n);
      check("combo_gap", n, 4);
      check("combo_step", 32'(HEXS), 32'h0600);

      // Asynchronous reset between clock edges, with sw_load held through release.
      tick(); tick();
      #3;
      rst = 1'b1; sw_load = 1'b1; sw = 16'hABCD; mode = 2'b00;
      #1;
      check("async_rst_hexs", 32'(HEXS), 32'h0001);
      check("async_rst_dir", 32'(dir), 0);
      check("async_rst_tick", 32'(step_tick), 0);
      tick();
      rst = 1'b0;
      wait_step(20, n);
      check("post_rst_gap", n, 4);
      check("post_rst_noload", 32'(HEXS), 32'h0001);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
